// File: rtl/rob_wb_arbiter.sv
// ROB writeback arbiter: NREQ one-entry holding buffers share NPORTS ROB write
// ports under a rotating-priority scheduler; flush drops all buffered results.
module rob_wb_arbiter #(
  parameter int ROB_DEPTHLOG = 4,
  parameter int NREQ         = 4,
  parameter int NPORTS       = 2,
  parameter int DATA_W       = 32
) (
  input  logic                             i_clock,
  input  logic                             i_reset_n,
  input  logic [NREQ-1:0]                  i_req_valid,
  input  logic [NREQ*ROB_DEPTHLOG-1:0]     i_req_slot,
  input  logic [NREQ*DATA_W-1:0]           i_req_data,
  output logic [NREQ-1:0]                  o_req_ready,
  input  logic                             i_flush,
  input  logic                             i_rob_wr_stall,
  output logic [NPORTS-1:0]                o_wr_valid,
  output logic [NPORTS*ROB_DEPTHLOG-1:0]   o_wr_slot,
  output logic [NPORTS*DATA_W-1:0]         o_wr_data
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]         r_hold_valid;
  logic [ROB_DEPTHLOG-1:0] r_hold_slot [NREQ];
  logic [DATA_W-1:0]       r_hold_data [NREQ];
  logic [PTR_W-1:0]        r_rr_ptr;

  logic [NREQ-1:0]   w_cand;
  logic [NREQ-1:0]   w_grant;
  logic [NREQ-1:0]   w_accept;
  logic [NPORTS-1:0] w_port_used;
  logic [PTR_W-1:0]  w_next_ptr;
  logic              w_go;

  assign w_go = ~i_rob_wr_stall & ~i_flush;

  // Rotated scan from r_rr_ptr; the k-th held buffer found drives port k.
  always_comb begin
    int unsigned      idx;
    int unsigned      cnt;
    logic [PTR_W-1:0] sel;
    w_cand      = '0;
    w_port_used = '0;
    o_wr_slot   = '0;
    o_wr_data   = '0;
    w_next_ptr  = r_rr_ptr;
    idx         = 0;
    cnt         = 0;
    sel         = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      sel = PTR_W'(idx);
      if (r_hold_valid[sel] && cnt < NPORTS) begin
        w_cand[sel]                                   = 1'b1;
        w_port_used[cnt]                              = 1'b1;
        o_wr_slot[cnt*ROB_DEPTHLOG +: ROB_DEPTHLOG]   = r_hold_slot[sel];
        o_wr_data[cnt*DATA_W +: DATA_W]               = r_hold_data[sel];
        w_next_ptr                                    = PTR_W'((idx + 1) % NREQ);
        cnt                                           = cnt + 1;
      end
    end
  end

  assign w_grant     = w_cand & {NREQ{w_go}};
  assign o_wr_valid  = w_port_used & {NPORTS{w_go}};
  assign o_req_ready = {NREQ{~i_flush}} & (~r_hold_valid | w_grant);
  assign w_accept    = i_req_valid & o_req_ready;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_hold_valid <= '0;
      r_rr_ptr     <= '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
        r_hold_slot[i] <= '0;
        r_hold_data[i] <= '0;
      end
    end else begin
      if (i_flush) begin
        r_hold_valid <= '0;
      end else begin
        for (int unsigned i = 0; i < NREQ; i++) begin
          if (w_accept[i]) begin
            r_hold_valid[i] <= 1'b1;
            r_hold_slot[i]  <= i_req_slot[i*ROB_DEPTHLOG +: ROB_DEPTHLOG];
            r_hold_data[i]  <= i_req_data[i*DATA_W +: DATA_W];
          end else if (w_grant[i]) begin
            r_hold_valid[i] <= 1'b0;
          end
        end
      end
      if (|w_grant) r_rr_ptr <= w_next_ptr;
    end
  end

endmodule
